// File: rtl/ram_arbiter.sv
// Two-client arbiter in front of one shared single-port RAM.
// One operation in flight. A collision is resolved round-robin and the
// losing request is parked as pending, then issued straight from S3.
module ram_arbiter #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_0,
  input  logic          we_0,
  input  logic [AW-1:0] addr_0,
  input  logic [DW-1:0] wdata_0,
  input  logic          start_1,
  input  logic          we_1,
  input  logic [AW-1:0] addr_1,
  input  logic [DW-1:0] wdata_1,
  output logic          ready_0,
  output logic          done_0,
  output logic [DW-1:0] rdata_0,
  output logic          ready_1,
  output logic          done_1,
  output logic [DW-1:0] rdata_1
);

  localparam int unsigned DEPTH = 2 ** AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S2   = 2'd2,
    S3   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  // Shared storage; contents survive reset
  logic [DW-1:0] r_mem [DEPTH];

  // Operation currently in flight
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic          r_id;

  // Parked losing request from a collision
  logic          r_pend;
  logic          r_pwe;
  logic [AW-1:0] r_paddr;
  logic [DW-1:0] r_pwdata;
  logic          r_pid;

  logic          r_rr;
  logic          r_ready;
  logic [1:0]    r_done;
  logic [DW-1:0] r_rdata_0;
  logic [DW-1:0] r_rdata_1;

  logic          w_accept;
  logic          w_collide;
  logic          w_gid;
  logic          w_issue_pend;
  logic          w_complete;

  // Granted / losing request fields selected by grant id
  logic          w_g_we;
  logic [AW-1:0] w_g_addr;
  logic [DW-1:0] w_g_wdata;
  logic          w_l_we;
  logic [AW-1:0] w_l_addr;
  logic [DW-1:0] w_l_wdata;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state, arbitration and sequencing strobes
  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_collide    = 1'b0;
    w_gid        = 1'b0;
    w_issue_pend = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_pend && (start_0 || start_1)) begin
          w_accept = 1'b1;
          w_next   = S1;
          if (start_0 && start_1) begin
            w_collide = 1'b1;
            w_gid     = r_rr;
          end else begin
            w_gid     = start_1;
          end
        end
      end
      S1: w_next = S2;
      S2: w_next = S3;
      S3: begin
        w_complete = 1'b1;
        if (r_pend) begin
          w_issue_pend = 1'b1;
          w_next       = S1;
        end else begin
          w_next       = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Request field muxes for the winner and the loser
  always_comb begin
    w_g_we    = w_gid ? we_1    : we_0;
    w_g_addr  = w_gid ? addr_1  : addr_0;
    w_g_wdata = w_gid ? wdata_1 : wdata_0;
    w_l_we    = w_gid ? we_0    : we_1;
    w_l_addr  = w_gid ? addr_0  : addr_1;
    w_l_wdata = w_gid ? wdata_0 : wdata_1;
  end

  // Request capture, pending slot, completion status and read results
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_id      <= 1'b0;
      r_pend    <= 1'b0;
      r_pwe     <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pid     <= 1'b0;
      r_rr      <= 1'b0;
      r_ready   <= 1'b1;
      r_done    <= 2'b00;
      r_rdata_0 <= '0;
      r_rdata_1 <= '0;
    end else begin
      r_ready <= (w_next == IDLE);

      if (w_complete) begin
        r_done[r_id] <= 1'b1;
        if (!r_we) begin
          if (r_id) begin
            r_rdata_1 <= r_mem[r_addr];
          end else begin
            r_rdata_0 <= r_mem[r_addr];
          end
        end
      end

      if (w_accept) begin
        r_we          <= w_g_we;
        r_addr        <= w_g_addr;
        r_wdata       <= w_g_wdata;
        r_id          <= w_gid;
        r_rr          <= ~w_gid;
        r_done[w_gid] <= 1'b0;
        if (w_collide) begin
          r_pend         <= 1'b1;
          r_pwe          <= w_l_we;
          r_paddr        <= w_l_addr;
          r_pwdata       <= w_l_wdata;
          r_pid          <= ~w_gid;
          r_done[~w_gid] <= 1'b0;
        end
      end else if (w_issue_pend) begin
        r_we    <= r_pwe;
        r_addr  <= r_paddr;
        r_wdata <= r_pwdata;
        r_id    <= r_pid;
        r_pend  <= 1'b0;
      end
    end
  end

  // RAM write port; commits in the last step of a write
  always_ff @(posedge clk) begin
    if ((r_state == S3) && r_we) begin
      r_mem[r_addr] <= r_wdata;
    end
  end

  assign ready_0 = r_ready;
  assign ready_1 = r_ready;
  assign done_0  = r_done[0];
  assign done_1  = r_done[1];
  assign rdata_0 = r_rdata_0;
  assign rdata_1 = r_rdata_1;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: transaction-level model with completion times,
// per-cycle compare on the falling edge, plus directed literal checks.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_0 = 1'b0, we_0 = 1'b0, start_1 = 1'b0, we_1 = 1'b0;
  logic [3:0]  addr_0 = '0, addr_1 = '0;
  logic [15:0] wdata_0 = '0, wdata_1 = '0;
  logic        ready_0, done_0, ready_1, done_1;
  logic [15:0] rdata_0, rdata_1;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  ram_arbiter #(.DW(16), .AW(4)) dut (
    .clk(clk), .rst(rst),
    .start_0(start_0), .we_0(we_0), .addr_0(addr_0), .wdata_0(wdata_0),
    .start_1(start_1), .we_1(we_1), .addr_1(addr_1), .wdata_1(wdata_1),
    .ready_0(ready_0), .done_0(done_0), .rdata_0(rdata_0),
    .ready_1(ready_1), .done_1(done_1), .rdata_1(rdata_1)
  );

  always #5 clk = ~clk;

  // Model: queue of scheduled operations, each with the cycle it completes
  typedef struct {
    int          id;
    bit          we;
    int          addr;
    logic [15:0] wdata;
    int          due;
  } op_t;

  op_t         q[$];
  int          m_cyc = 0;
  bit          m_ready = 1'b1;
  bit          m_done [2] = '{1'b0, 1'b0};
  logic [15:0] m_rdata [2] = '{16'h0, 16'h0};
  bit          m_rknown [2] = '{1'b1, 1'b1};
  logic [15:0] m_mem [16];
  bit          m_valid [16];
  int          m_rr = 0;

  task automatic push_op(input int c, input int due);
    op_t o;
    o.id    = c;
    o.we    = (c == 1) ? we_1 : we_0;
    o.addr  = (c == 1) ? int'(addr_1) : int'(addr_0);
    o.wdata = (c == 1) ? wdata_1 : wdata_0;
    o.due   = due;
    q.push_back(o);
    m_done[c] = 1'b0;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_ready  = 1'b1;
      m_done   = '{1'b0, 1'b0};
      m_rdata  = '{16'h0, 16'h0};
      m_rknown = '{1'b1, 1'b1};
      m_rr     = 0;
    end else begin
      bit idle_before;
      m_cyc++;
      idle_before = (q.size() == 0);
      while (q.size() > 0 && q[0].due == m_cyc) begin
        op_t o;
        o = q.pop_front();
        if (o.we) begin
          m_mem[o.addr]   = o.wdata;
          m_valid[o.addr] = 1'b1;
        end else begin
          m_rdata[o.id]  = m_mem[o.addr];
          m_rknown[o.id] = m_valid[o.addr];
        end
        m_done[o.id] = 1'b1;
      end
      if (idle_before) begin
        if (start_0 && start_1) begin
          push_op(m_rr, m_cyc + 3);
          push_op(1 - m_rr, m_cyc + 6);
          m_rr = 1 - m_rr;
        end else if (start_0 || start_1) begin
          int c;
          c = start_1 ? 1 : 0;
          push_op(c, m_cyc + 3);
          m_rr = 1 - c;
        end
      end
      m_ready = (q.size() == 0);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_ready_0", 32'(ready_0), 32'(m_ready));
      chk("m_ready_1", 32'(ready_1), 32'(m_ready));
      chk("m_done_0", 32'(done_0), 32'(m_done[0]));
      chk("m_done_1", 32'(done_1), 32'(m_done[1]));
      if (m_rknown[0]) chk("m_rdata_0", 32'(rdata_0), 32'(m_rdata[0]));
      if (m_rknown[1]) chk("m_rdata_1", 32'(rdata_1), 32'(m_rdata[1]));
    end
  end

  task automatic drive(input bit c, input bit we, input logic [3:0] a, input logic [15:0] d);
    if (c) begin
      start_1 = 1'b1; we_1 = we; addr_1 = a; wdata_1 = d;
    end else begin
      start_0 = 1'b1; we_0 = we; addr_0 = a; wdata_0 = d;
    end
  endtask

  // One-cycle start pulse; returns at the falling edge after the accept edge
  task automatic issue(input bit c, input bit we, input logic [3:0] a, input logic [15:0] d);
    @(negedge clk);
    drive(c, we, a, d);
    @(negedge clk);
    start_0 = 1'b0;
    start_1 = 1'b0;
  endtask

  task automatic issue2(input bit we0, input logic [3:0] a0, input logic [15:0] d0,
                        input bit we1, input logic [3:0] a1, input logic [15:0] d1);
    @(negedge clk);
    drive(1'b0, we0, a0, d0);
    drive(1'b1, we1, a1, d1);
    @(negedge clk);
    start_0 = 1'b0;
    start_1 = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cmp_en = 1'b1;
    chk("rst_ready_0", 32'(ready_0), 32'h1);
    chk("rst_ready_1", 32'(ready_1), 32'h1);
    chk("rst_done_0", 32'(done_0), 32'h0);
    chk("rst_done_1", 32'(done_1), 32'h0);
    chk("rst_rdata_0", 32'(rdata_0), 32'h0);
    chk("rst_rdata_1", 32'(rdata_1), 32'h0);

    // Single write then read-back by client 0
    issue(1'b0, 1'b1, 4'd3, 16'h1234);
    chk("wr_ready_E", 32'(ready_0), 32'h0);
    repeat (2) @(negedge clk);
    chk("wr_ready_E2", 32'(ready_0), 32'h0);
    chk("wr_done_E2", 32'(done_0), 32'h0);
    @(negedge clk);
    chk("wr_done_E3", 32'(done_0), 32'h1);
    chk("wr_ready_E3", 32'(ready_0), 32'h1);
    chk("wr_rdata_kept", 32'(rdata_0), 32'h0);
    issue(1'b0, 1'b0, 4'd3, 16'h0);
    chk("rd_done_clr", 32'(done_0), 32'h0);
    repeat (3) @(negedge clk);
    chk("rd_rdata_0", 32'(rdata_0), 32'h1234);
    chk("rd_done_E3", 32'(done_0), 32'h1);

    // Collision after reset: client 0 wins
    do_reset();
    issue2(1'b1, 4'd5, 16'hAAAA, 1'b0, 4'd5, 16'h0);
    repeat (3) @(negedge clk);
    chk("col_done0_E3", 32'(done_0), 32'h1);
    chk("col_done1_E3", 32'(done_1), 32'h0);
    chk("col_ready_E3", 32'(ready_1), 32'h0);
    repeat (3) @(negedge clk);
    chk("col_done1_E6", 32'(done_1), 32'h1);
    chk("col_rdata1_E6", 32'(rdata_1), 32'hAAAA);
    chk("col_ready_E6", 32'(ready_0), 32'h1);

    // Fairness: client 1 granted first; a start while busy is ignored
    issue2(1'b0, 4'd5, 16'h0, 1'b1, 4'd5, 16'h1357);
    drive(1'b1, 1'b1, 4'd9, 16'hFFFF);
    @(negedge clk);
    start_1 = 1'b0;
    repeat (2) @(negedge clk);
    chk("fair_done1_E3", 32'(done_1), 32'h1);
    chk("fair_done0_E3", 32'(done_0), 32'h0);
    repeat (3) @(negedge clk);
    chk("fair_rdata0_E6", 32'(rdata_0), 32'h1357);
    chk("fair_done0_E6", 32'(done_0), 32'h1);
    chk("fair_rdata1_kept", 32'(rdata_1), 32'hAAAA);
    repeat (3) @(negedge clk);
    chk("ign_done1", 32'(done_1), 32'h1);
    chk("ign_ready", 32'(ready_1), 32'h1);

    // Reset in the middle of a write aborts it
    issue(1'b1, 1'b1, 4'd7, 16'h0F0F);
    repeat (3) @(negedge clk);
    issue(1'b1, 1'b1, 4'd7, 16'h5555);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_done_1", 32'(done_1), 32'h0);
    chk("abort_ready_1", 32'(ready_1), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_done", 32'(done_1), 32'h0);
    issue(1'b1, 1'b0, 4'd7, 16'h0);
    repeat (3) @(negedge clk);
    chk("abort_rdata_1", 32'(rdata_1), 32'h0F0F);
    chk("abort_rd_done", 32'(done_1), 32'h1);

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
